// File: rtl/instr_align_buffer.sv
// Prefetch/realignment queue: fetches aligned 32-bit words, holds them as halfwords,
// and presents one 16- or 32-bit instruction per cycle (including word-straddling ones).
module instr_align_buffer #(
  parameter int          DEPTH_HW = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic        instr_is_c,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus_len
);

  localparam int IW = $clog2(DEPTH_HW);
  localparam int CW = $clog2(DEPTH_HW + 1);

  logic [15:0]   q [DEPTH_HW];
  logic [IW-1:0] head;
  logic [CW-1:0] count;
  logic [31:0]   fetch_addr;
  logic [31:0]   out_pc;
  logic          drop_low;

  logic [15:0]   h0, h1;
  logic [IW-1:0] tail0, tail1;
  logic [CW-1:0] push_n, pop_n;
  logic          pop;
  logic          unused_pc_bit0;

  // Circular index add; off never exceeds DEPTH_HW so one subtraction suffices.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input logic [CW-1:0] off);
    int s;
    s = int'(base) + int'(off);
    if (s >= DEPTH_HW) s = s - DEPTH_HW;
    return IW'(s);
  endfunction

  assign unused_pc_bit0 = redirect_pc[0];

  always_comb begin
    h0          = q[head];
    h1          = q[wrap_idx(head, CW'(1))];
    instr_is_c  = (h0[1:0] != 2'b11);
    instr_valid = !rst && (count >= CW'(1)) && (instr_is_c || count >= CW'(2));
    instr_out   = instr_is_c ? {16'h0000, h0} : {h1, h0};
    instr_pc    = out_pc;
    pc_plus_len = out_pc + (instr_is_c ? 32'd2 : 32'd4);
    imem_addr   = fetch_addr;
    // Room check uses the current count only; a same-cycle pop earns no credit.
    imem_req    = !rst && !redirect && (count <= CW'(DEPTH_HW - 2));
    pop         = instr_valid && !stall && !redirect;
    push_n      = imem_req ? (drop_low ? CW'(1) : CW'(2)) : CW'(0);
    pop_n       = pop ? (instr_is_c ? CW'(1) : CW'(2)) : CW'(0);
    tail0       = wrap_idx(head, count);
    tail1       = wrap_idx(head, count + CW'(1));
  end

  always_ff @(posedge clk) begin
    if (imem_req) begin
      if (drop_low) begin
        q[tail0] <= imem_rdata[31:16];
      end else begin
        q[tail0] <= imem_rdata[15:0];
        q[tail1] <= imem_rdata[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      count      <= '0;
      fetch_addr <= RESET_PC;
      out_pc     <= RESET_PC;
      drop_low   <= 1'b0;
    end else if (redirect) begin
      head       <= '0;
      count      <= '0;
      fetch_addr <= {redirect_pc[31:2], 2'b00};
      out_pc     <= {redirect_pc[31:1], 1'b0};
      drop_low   <= redirect_pc[1];
    end else begin
      if (imem_req) begin
        fetch_addr <= fetch_addr + 32'd4;
        drop_low   <= 1'b0;
      end
      if (pop) begin
        head   <= wrap_idx(head, pop_n);
        out_pc <= pc_plus_len;
      end
      count <= count + push_n - pop_n;
    end
  end

endmodule

// File: tb/tb_instr_align_buffer.sv
// Directed bench for instr_align_buffer: reset, mixed stream, redirect, stall, reset pulse.
module tb_instr_align_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        instr_is_c;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus_len;

  logic [31:0] mem [0:127];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[8:2]];

  instr_align_buffer #(.DEPTH_HW(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_is_c(instr_is_c), .instr_pc(instr_pc), .pc_plus_len(pc_plus_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_word(input int k);
    return (32'(k) << 20) | 32'h0000_0013;
  endfunction

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    // Reset and first fetch
    mem[0] = 32'h0050_0093;
    cyc(); #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    cyc(); rst = 1'b0; #1;
    chk("s1_c0_req", imem_req, 1);
    chk("s1_c0_addr", imem_addr, 32'h0);
    chk("s1_c0_valid", instr_valid, 0);
    cyc(); #1;
    chk("s1_c1_valid", instr_valid, 1);
    chk("s1_c1_out", instr_out, 32'h0050_0093);
    chk("s1_c1_pc", instr_pc, 32'h0);
    chk("s1_c1_is_c", instr_is_c, 0);
    chk("s1_c1_ppl", pc_plus_len, 32'h4);

    // Mixed compressed / straddling stream
    rst = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0093_4505;
    mem[1]  = 32'h0001_0090;
    mem[64] = 32'h4505_AAAA;
    cyc(); cyc(); rst = 1'b0; #1;
    chk("s2_c0_req", imem_req, 1);
    cyc(); #1;
    chk("s2_i0_out", instr_out, 32'h0000_4505);
    chk("s2_i0_is_c", instr_is_c, 1);
    chk("s2_i0_pc", instr_pc, 32'h0);
    chk("s2_i0_ppl", pc_plus_len, 32'h2);
    cyc(); #1;
    chk("s2_i1_valid", instr_valid, 1);
    chk("s2_i1_out", instr_out, 32'h0090_0093);
    chk("s2_i1_is_c", instr_is_c, 0);
    chk("s2_i1_pc", instr_pc, 32'h2);
    chk("s2_i1_ppl", pc_plus_len, 32'h6);
    cyc(); #1;
    chk("s2_i2_out", instr_out, 32'h0000_0001);
    chk("s2_i2_is_c", instr_is_c, 1);
    chk("s2_i2_pc", instr_pc, 32'h6);

    // Redirect to a halfword-2 target
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0102; #1;
    chk("s3_redir_req", imem_req, 0);
    cyc(); redirect = 1'b0; #1;
    chk("s3_r1_addr", imem_addr, 32'h0000_0100);
    chk("s3_r1_req", imem_req, 1);
    chk("s3_r1_valid", instr_valid, 0);
    cyc(); #1;
    chk("s3_r2_valid", instr_valid, 1);
    chk("s3_r2_pc", instr_pc, 32'h0000_0102);
    chk("s3_r2_out", instr_out, 32'h0000_4505);
    chk("s3_r2_is_c", instr_is_c, 1);
    chk("s3_r2_ppl", pc_plus_len, 32'h0000_0104);

    // Stall held with all-32-bit code, then release
    rst = 1'b1; stall = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = addi_word(i);
    cyc(); cyc(); rst = 1'b0; #1;
    chk("s4_c0_req", imem_req, 1);
    for (int k = 1; k <= 6; k++) begin
      cyc(); #1;
      chk("s4_stall_valid", instr_valid, 1);
      chk("s4_stall_pc", instr_pc, 32'h0);
      chk("s4_stall_out", instr_out, 32'h0000_0013);
      chk("s4_stall_req", imem_req, (k <= 2) ? 32'd1 : 32'd0);
      if (k == 3) chk("s4_full_addr", imem_addr, 32'h0000_000C);
    end
    cyc(); stall = 1'b0; #1;
    chk("s4_rel_pc", instr_pc, 32'h0);
    chk("s4_rel_out", instr_out, addi_word(0));
    for (int k = 1; k <= 7; k++) begin
      cyc(); #1;
      chk("s4_run_valid", instr_valid, 1);
      chk("s4_run_pc", instr_pc, 32'(4 * k));
      chk("s4_run_out", instr_out, addi_word(k));
    end

    // Redirect and stall in the same cycle
    cyc(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040; #1;
    chk("s5_stale_pc", instr_pc, 32'h0000_0020);
    chk("s5_redir_req", imem_req, 0);
    cyc(); redirect = 1'b0; stall = 1'b0; #1;
    chk("s5_r1_valid", instr_valid, 0);
    chk("s5_r1_addr", imem_addr, 32'h0000_0040);
    cyc(); #1;
    chk("s5_r2_valid", instr_valid, 1);
    chk("s5_r2_pc", instr_pc, 32'h0000_0040);
    chk("s5_r2_out", instr_out, addi_word(16));
    cyc(); #1;
    chk("s5_r3_pc", instr_pc, 32'h0000_0044);
    chk("s5_r3_out", instr_out, addi_word(17));

    // One-cycle reset pulse with four halfwords queued
    cyc(); stall = 1'b1; #1;
    chk("s6_pre_pc", instr_pc, 32'h0000_0048);
    cyc(); stall = 1'b0; rst = 1'b1; #1;
    chk("s6_rst_valid", instr_valid, 0);
    chk("s6_rst_req", imem_req, 0);
    cyc(); rst = 1'b0; #1;
    chk("s6_c0_valid", instr_valid, 0);
    chk("s6_c0_addr", imem_addr, 32'h0);
    chk("s6_c0_req", imem_req, 1);
    cyc(); #1;
    chk("s6_c1_valid", instr_valid, 1);
    chk("s6_c1_pc", instr_pc, 32'h0);
    chk("s6_c1_out", instr_out, addi_word(0));
    cyc(); #1;
    chk("s6_c2_pc", instr_pc, 32'h4);
    chk("s6_c2_out", instr_out, addi_word(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_align_buffer.md
Name: instr_align_buffer

Overview:
- Fetch-side prefetch/realignment queue that replaces the bare PC register ahead of the compressed-instruction decompressor.
- Fetches word-aligned 32-bit words from instruction memory and holds them as a halfword FIFO.
- Presents one instruction per cycle at halfword granularity: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary.
- Handles pipeline stalls and branch/jump redirects from the execute stage.

Parameters:
- DEPTH_HW, 6, halfword queue capacity; minimum 4, must be even.
- RESET_PC, 32'h0000_0000, PC after reset; must be word aligned.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  32  word-aligned fetch address; bits[1:0] always 0
- imem_req  out  1  fetch enable this cycle
- imem_rdata  in  32  instruction word; combinational from imem_addr, same cycle
- redirect  in  1  taken branch/jump from execute stage
- redirect_pc  in  32  redirect target; bit0 ignored
- stall  in  1  downstream not accepting this cycle
- instr_valid  out  1  instr_out/instr_pc valid
- instr_out  out  32  raw instruction to decompressor; compressed = {16'h0, hw}
- instr_is_c  out  1  1 = 16-bit instruction (head bits[1:0] != 2'b11)
- instr_pc  out  32  PC of instr_out
- pc_plus_len  out  32  instr_pc+2 if instr_is_c, else instr_pc+4, mod 2^32

Behaviour:
- State: halfword queue (head index, count 0..DEPTH_HW), fetch_addr, drop_low flag, out_pc.
- Reset: while rst=1, count=0, fetch_addr=RESET_PC, out_pc=RESET_PC, drop_low=0. instr_valid=0 and imem_req=0 while rst is high. Reset asserted mid-operation discards all queued data at the same edge.
- Fetch:
  - imem_req = !rst && !redirect && count <= DEPTH_HW-2. This uses the current count; same-cycle pops are not credited.
  - On req at the clock edge: push low then high halfword of imem_rdata, and fetch_addr += 4 (wraps at 2^32).
  - If drop_low=1: push only the high halfword, then clear drop_low.
- Output:
  - Head halfword h0, next h1.
  - instr_valid = count>=1 && (h0[1:0]!=2'b11 || count>=2).
  - instr_out = compressed ? {16'h0,h0} : {h1,h0}.
  - All outputs are combinational from state; there is no output register.
- Accept: when instr_valid && !stall, pop 1 (compressed) or 2 halfwords and set out_pc = pc_plus_len. Push and pop in the same cycle are both applied; count_next = count + pushed - popped.
- Stall: when stall=1, queue head, instr_out and instr_pc hold stable. Fetch continues until the room condition fails. No halfword is lost or duplicated.
- Redirect (highest priority after rst):
  - Queue cleared.
  - fetch_addr = {redirect_pc[31:2],2'b00}.
  - drop_low = redirect_pc[1].
  - out_pc = {redirect_pc[31:1],1'b0}.
  - No pop and no push that cycle; redirect overrides stall.
- Latency:
  - First instruction valid 1 cycle after its word is fetched.
  - After rst falls: cycle 0 fetches RESET_PC; cycle 1 instr_valid=1.
  - After redirect: fetch in cycle+1, valid in cycle+2. A 32-bit instruction at a halfword-2 target needs two fetches, so valid in cycle+3.
- Straddling 32-bit instruction with count==1: instr_valid=0 until the next word arrives.
- Full: count=DEPTH_HW-1 or DEPTH_HW → imem_req=0, fetch_addr holds.
- The queue never overflows; overflow is an assertion target for verification.

Test Plan:
- Reset, imem[0]=0x00500093: after rst falls, cycle 0 has imem_req=1, imem_addr=0. Cycle 1 has instr_valid=1, instr_out=0x00500093, instr_pc=0, instr_is_c=0, pc_plus_len=4.
- Mixed stream, imem[0]=0x00934505, imem[4]=0x00010090, no stall:
  - instr pc0 = 0x00004505, is_c=1, pc_plus_len=2.
  - then pc2 = 0x00900093, is_c=0, pc_plus_len=6.
  - then pc6 = 0x00000001, is_c=1.
- Redirect, redirect_pc=0x102 mid-stream, imem[0x100]=0x4505AAAA:
  - Queue flushed; imem_addr=0x100 next cycle; 0xAAAA is dropped.
  - Next valid instr_pc=0x102, instr_out=0x00004505, is_c=1.
- Stall held 6 cycles with all-32-bit code: instr_out and instr_pc constant. imem_req drops once count ≥ DEPTH_HW-1. After stall release, PCs step 0,4,8,... with no gaps or repeats.
- redirect=1 and stall=1 in the same cycle, redirect_pc=0x40: redirect wins; the next valid instr_pc is 0x40. The stale head is never presented again.
- rst pulsed for 1 cycle while count=4: next cycle count=0, instr_valid=0, imem_addr=RESET_PC. Execution restarts at RESET_PC.
